// File: rtl/task2_lfsr_pkg.sv
// rtl/task2_lfsr_pkg.sv - shared types, defaults and step function for the 16-bit Galois LFSR
//
// Purpose : common definitions for task2_lfsr and anything that needs to
//           predict its sequence. lfsr_next() is the single definition of
//           one Galois step; lfsr_seed_fix() maps the forbidden all-zero
//           seed onto a legal non-zero state.
// Ports   : none (package).
package task2_lfsr_pkg;

  localparam int LFSR_W = 16;

  typedef logic [LFSR_W-1:0] lfsr_t;

  // x^16 + x^14 + x^13 + x^11 + 1, maximal length (period 65535)
  localparam lfsr_t DEFAULT_SEED = 16'hACE1;
  localparam lfsr_t DEFAULT_TAPS = 16'hB400;

  // One Galois step: logical right shift, and the bit falling out of the
  // LSB decides whether the tap mask is folded back in.
  function automatic lfsr_t lfsr_next(lfsr_t s, lfsr_t taps);
    lfsr_t shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ taps) : shifted;
  endfunction

  // All-zero is the lock-up state of an XOR LFSR; a zero seed would never
  // leave it, so it is replaced by 1.
  function automatic lfsr_t lfsr_seed_fix(lfsr_t seed);
    return (seed == '0) ? lfsr_t'(1) : seed;
  endfunction

endpackage

// File: rtl/task2_lfsr.sv
// rtl/task2_lfsr.sv - free-running 16-bit maximal-length Galois LFSR
//
// Purpose : pseudo-random sequence source. Loads the seed N while n_reset
//           is high, then takes one Galois step on every rising clk edge.
//           No enable, no handshake.
// Params  : N     - seed (a zero seed is replaced by 16'h0001)
//           TAPS  - Galois feedback mask
//           WIDTH - register width, 16 only (matches lfsr_t)
// Ports   : q       out WIDTH  current state, straight from the register
//           clk     in  1      rising-edge clock
//           n_reset in  1      asynchronous reset, active HIGH despite the
//                              legacy name; loads the seed immediately
//           wrap    out 1      (only with TASK2_LFSR_WRAP_EN) registered
//                              one-cycle pulse in the cycle q has just
//                              returned to the reset value
// Macro   : TASK2_LFSR_WRAP_EN adds the wrap output and its flop.
// Positional order is fixed: (q, clk, n_reset[, wrap]).
module task2_lfsr
  import task2_lfsr_pkg::*;
#(
  parameter lfsr_t N     = DEFAULT_SEED,
  parameter lfsr_t TAPS  = DEFAULT_TAPS,
  parameter int    WIDTH = LFSR_W
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             n_reset
`ifdef TASK2_LFSR_WRAP_EN
  ,
  output logic             wrap
`endif
);

  localparam lfsr_t RESET_Q = lfsr_seed_fix(N);

  lfsr_t q_next;

  assign q_next = lfsr_next(q, TAPS);

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      q <= RESET_Q;
    end else begin
      q <= q_next;
    end
  end

`ifdef TASK2_LFSR_WRAP_EN
  // Look one step ahead so the pulse lines up with the cycle in which q
  // shows the reset value again. The reset-value cycle right after release
  // is not a wrap: wrap is still cleared from reset and q_next there is
  // the first step, which can only equal RESET_Q after a full period.
  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= (q_next == RESET_Q);
    end
  end
`endif

endmodule

// File: tb/tb_task2_lfsr.sv
// tb/tb_task2_lfsr.sv - self-checking bench for task2_lfsr (default, zero and unit seeds)
module tb_task2_lfsr;
  import task2_lfsr_pkg::*;

  localparam int PERIOD = 65535;

  typedef struct packed {
    lfsr_t q_def;  // instance with default seed
    lfsr_t q_alt;  // instances with seed 0 and seed 1 (same sequence)
    logic  wrap;   // expected wrap on the default instance
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  lfsr_t q_def, q_zero, q_one;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

`ifdef TASK2_LFSR_WRAP_EN
  logic wrap_def, wrap_zero, wrap_one;
  task2_lfsr #(.N(16'hACE1)) dut_def  (.q(q_def),  .clk(clk), .n_reset(rst), .wrap(wrap_def));
  task2_lfsr #(.N(16'h0000)) dut_zero (.q(q_zero), .clk(clk), .n_reset(rst), .wrap(wrap_zero));
  task2_lfsr #(.N(16'h0001)) dut_one  (.q(q_one),  .clk(clk), .n_reset(rst), .wrap(wrap_one));
`else
  task2_lfsr #(.N(16'hACE1)) dut_def  (.q(q_def),  .clk(clk), .n_reset(rst));
  task2_lfsr #(.N(16'h0000)) dut_zero (.q(q_zero), .clk(clk), .n_reset(rst));
  task2_lfsr #(.N(16'h0001)) dut_one  (.q(q_one),  .clk(clk), .n_reset(rst));
`endif

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_def"},  q_def,  16'hACE1);
    check({tag, "_zero"}, q_zero, 16'h0001);
    check({tag, "_one"},  q_one,  16'h0001);
`ifdef TASK2_LFSR_WRAP_EN
    check({tag, "_wrap"}, {15'b0, wrap_def}, 16'h0000);
`endif
  endtask

  // Pushes the expected post-edge state, lets one edge happen, then pops
  // and compares all instances against it.
  task automatic step_and_compare(inout lfsr_t m_def, inout lfsr_t m_alt, input int step);
    exp_t e;
    m_def = lfsr_next(m_def, DEFAULT_TAPS);
    m_alt = lfsr_next(m_alt, DEFAULT_TAPS);
    sb_q.push_back('{q_def: m_def, q_alt: m_alt, wrap: (step == PERIOD)});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("seq_def",  q_def,  e.q_def);
    check("seq_zero", q_zero, e.q_alt);
    check("seq_one",  q_one,  e.q_alt);
`ifdef TASK2_LFSR_WRAP_EN
    check("seq_wrap", {15'b0, wrap_def}, {15'b0, e.wrap});
`endif
  endtask

  initial begin
    lfsr_t m_def, m_alt;
    int    bad_def, bad_alt;

    // reset held while the clock runs: sample on both phases
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_reset_values("rst_hold_neg");
      @(posedge clk);
      #1;
      check_reset_values("rst_hold_pos");
    end

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("rst_release");

    m_def   = 16'hACE1;
    m_alt   = 16'h0001;
    bad_def = 0;
    bad_alt = 0;
    for (int s = 1; s <= PERIOD; s++) begin
      step_and_compare(m_def, m_alt, s);
      if (s == 1) begin
        check("step1_def", q_def, 16'hE270);
        check("step1_zero", q_zero, 16'hB400);
        check("step1_one", q_one, 16'hB400);
      end
      if (s == 2) begin
        check("step2_def", q_def, 16'h7138);
        check("step2_one", q_one, 16'h5A00);
      end
      if (s == 3) check("step3_def", q_def, 16'h389C);
      if (s < PERIOD) begin
        if (q_def == 16'hACE1 || q_def == 16'h0000) bad_def++;
        if (q_zero == 16'h0001 || q_zero == 16'h0000) bad_alt++;
      end
    end
    check("period_def", q_def, 16'hACE1);
    check("period_zero", q_zero, 16'h0001);
    check("period_one", q_one, 16'h0001);
    check("early_repeat_def", bad_def[15:0], 16'h0000);
    check("early_repeat_zero", bad_alt[15:0], 16'h0000);

    // one more step: sequence restarts and the wrap pulse is over
    step_and_compare(m_def, m_alt, PERIOD + 1);
    check("restart_def", q_def, 16'hE270);

    // a few steps into the sequence, assert reset between edges
    step_and_compare(m_def, m_alt, PERIOD + 2);
    step_and_compare(m_def, m_alt, PERIOD + 3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    @(posedge clk);
    #1;
    check_reset_values("rst_async_hold");

    @(negedge clk);
    rst   = 1'b0;
    m_def = 16'hACE1;
    m_alt = 16'h0001;
    for (int s = 1; s <= 3; s++) step_and_compare(m_def, m_alt, s);
    check("rerun_step3_def", q_def, 16'h389C);
    check("scoreboard_empty", 16'(sb_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/task2_lfsr.md
Name: task2_lfsr

Overview:
16-bit Galois linear-feedback shift register, maximal length, pseudo-random sequence generator.
- Loads a parameterised seed on reset, then advances one state per rising clock edge.
- Free-running source for stimulus, scrambling and test-pattern use elsewhere in the design.
- Stand-alone leaf block with no handshake.

Parameters:
- N, 16'hACE1 (16'b1010110011100001): seed loaded on reset.
- TAPS, 16'hB400: Galois feedback mask (taps 16,14,13,11), maximal-length polynomial.
- WIDTH, 16: register width. Only 16 is required; N and TAPS are WIDTH wide.

Ports:
- clk  input  1  rising-edge clock.
- n_reset  input  1  asynchronous reset, active-high. Asserted (1) loads the seed; the legacy name is kept.
- q  output  WIDTH  current LFSR state, driven directly from a register.
- Positional instantiation order is fixed: (q, clk, n_reset).

Behaviour:
- Reset: while n_reset = 1, q = N immediately, independent of clk. This holds for assertion at any time, including mid-sequence.
- Reset release: takes effect asynchronously. The first update occurs on the first rising clk edge with n_reset = 0.
- Each rising clk edge with n_reset = 0: if q[0] = 1, q <= (q >> 1) ^ TAPS; else q <= q >> 1. The shift is logical, with 0 shifted into the MSB.
- Latency: one clock per step. q is registered, with no combinational path from inputs to q.
- Sequence from 0xACE1 with the default TAPS: 0xACE1 -> 0xE270 -> 0x7138 -> 0x389C -> ...
- Period is 65535 for any non-zero seed. After 65535 steps q returns to N.
- All-zero lock-up: if N = 0, the reset value is 16'h0001 instead of N. The all-zero state is otherwise unreachable.
- No enable input; the register advances every clock.

Optional Feature:
- Macro TASK2_LFSR_WRAP_EN.
- When defined:
  - Adds output port wrap (1 bit, appended after n_reset).
  - wrap is registered. It is 1 for exactly one cycle, the cycle in which q has just returned to the reset value after at least one step.
  - It is 0 during and immediately after reset, including the first cycle q = N post-reset.
  - With the default parameters, wrap first pulses after 65535 steps and every 65535 cycles thereafter.
- When undefined: no wrap port, no extra logic. Port list and behaviour are exactly as above.

Decomposition:
- Shared package task2_lfsr_pkg holds:
  - localparam LFSR_W = 16
  - DEFAULT_SEED = 16'hACE1
  - DEFAULT_TAPS = 16'hB400
  - typedef logic [LFSR_W-1:0] lfsr_t
  - a pure function lfsr_next(lfsr_t s, lfsr_t taps), used by both RTL and bench as the reference model.
- No sub-module; a single always_ff plus the package function is sufficient.

Test Plan:
- Reset: hold n_reset = 1 with clk toggling -> q = 0xACE1 throughout. Assert n_reset mid-sequence, between edges -> q = 0xACE1 immediately, with no clock needed.
- First steps after release: edges 1, 2, 3 -> q = 0xE270, 0x7138, 0x389C.
- Full period: run 65535 edges after release -> q = 0xACE1 again. No intermediate state equals 0xACE1 or 0x0000. Compare every cycle against lfsr_next.
- Zero seed: instantiate with N = 0 -> reset value 0x0001, first step 0xB400, never 0x0000.
- Alternate seed: N = 16'h0001 -> step 1 = 0xB400, step 2 = 0x5A00, period 65535.
- With TASK2_LFSR_WRAP_EN: wrap = 0 for the first 65534 steps, then 1 for exactly one cycle when q returns to 0xACE1, and repeats every 65535 cycles. Without the macro, the build has no wrap port.
